// File: rtl/ht_free_ptr_pool.sv
// Free-pointer pool: a circular FIFO of unused data-table pointers with a registered head and an
// optional per-pointer allocation bitmap that rejects double and out-of-range frees.
module ht_free_ptr_pool #(
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned DEPTH             = 2 ** ADDR_WIDTH,
  parameter int unsigned CHECK_DOUBLE_FREE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_done_o,
  output logic                  alloc_val_o,
  output logic [ADDR_WIDTH-1:0] alloc_ptr_o,
  input  logic                  alloc_ready_i,
  input  logic                  free_val_i,
  input  logic [ADDR_WIDTH-1:0] free_ptr_i,
  output logic                  free_ready_o,
  output logic [ADDR_WIDTH:0]   free_cnt_o,
  output logic                  err_double_free_o,
  output logic                  err_range_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {StInit, StRun} state_e;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  // Reset asserts asynchronously but releases only after two clean clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  state_e                state_q;
  logic [IdxW-1:0]       init_cnt_q;
  logic [IdxW-1:0]       rd_ptr_q;
  logic [IdxW-1:0]       wr_ptr_q;
  logic [ADDR_WIDTH:0]   fifo_cnt_q;
  logic                  pf_val_q;
  logic [ADDR_WIDTH-1:0] pf_ptr_q;
  logic [DEPTH-1:0]      used_q;
  logic                  init_done_q;
  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  logic                  run;
  logic                  in_range;
  logic                  dbl;
  logic                  alloc_fire;
  logic                  pf_load;
  logic                  fifo_wr;
  logic [IdxW-1:0]       free_idx;
  logic [ADDR_WIDTH-1:0] wr_data;

  assign free_cnt_o  = fifo_cnt_q + (ADDR_WIDTH + 1)'(pf_val_q);
  assign init_done_o = init_done_q;
  assign alloc_val_o = pf_val_q;
  assign alloc_ptr_o = pf_ptr_q;

  always_comb begin
    run      = (state_q == StRun);
    free_idx = free_ptr_i[IdxW-1:0];
    in_range = ({1'b0, free_ptr_i} < DepthCnt);
    // Without the bitmap, the only detectable illegal free is one into a full pool.
    if (CHECK_DOUBLE_FREE != 0) begin
      dbl = !used_q[free_idx];
    end else begin
      dbl = (free_cnt_o == DepthCnt);
    end
    err_range_o       = run && free_val_i && !in_range;
    err_double_free_o = run && free_val_i && in_range && dbl;
    free_ready_o      = run && free_val_i && in_range && !dbl;
    alloc_fire        = pf_val_q && alloc_ready_i;
    pf_load           = run && (fifo_cnt_q != '0) && (!pf_val_q || alloc_fire);
    fifo_wr           = (state_q == StInit) || free_ready_o;
    wr_data           = run ? free_ptr_i : ADDR_WIDTH'(init_cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      pf_val_q    <= 1'b0;
      pf_ptr_q    <= '0;
      used_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == StInit) begin
        init_cnt_q <= next_idx(init_cnt_q);
        if (init_cnt_q == LastIdx) begin
          state_q     <= StRun;
          init_done_q <= 1'b1;
        end
      end
      if (fifo_wr) begin
        wr_ptr_q <= next_idx(wr_ptr_q);
      end
      if (pf_load) begin
        rd_ptr_q <= next_idx(rd_ptr_q);
        pf_val_q <= 1'b1;
        pf_ptr_q <= mem[rd_ptr_q];
      end else if (alloc_fire) begin
        pf_val_q <= 1'b0;
      end
      fifo_cnt_q <= fifo_cnt_q + (ADDR_WIDTH + 1)'(fifo_wr) - (ADDR_WIDTH + 1)'(pf_load);
      if (alloc_fire) begin
        used_q[pf_ptr_q[IdxW-1:0]] <= 1'b1;
      end
      if (free_ready_o) begin
        used_q[free_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ht_free_ptr_pool.md
HT_FREE_PTR_POOL -- requirements
Module: ht_free_ptr_pool

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning width of a data-table pointer.
REQ-002 SHALL have parameter DEPTH, default 2**ADDR_WIDTH, meaning number of managed pointers (legal range 2..2**ADDR_WIDTH).
REQ-003 SHALL have parameter CHECK_DOUBLE_FREE, default 1, meaning that when 1 a per-pointer used bitmap rejects illegal frees.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port init_done_o  output  1  pool initialised and operational.
REQ-007 SHALL have port alloc_val_o  output  1  a free pointer is offered.
REQ-008 SHALL have port alloc_ptr_o  output  ADDR_WIDTH  offered pointer.
REQ-009 SHALL have port alloc_ready_i  input  1  consumer takes the offered pointer.
REQ-010 SHALL have port free_val_i  input  1  pointer return request.
REQ-011 SHALL have port free_ptr_i  input  ADDR_WIDTH  pointer being returned.
REQ-012 SHALL have port free_ready_o  output  1  free request accepted this cycle.
REQ-013 SHALL have port free_cnt_o  output  ADDR_WIDTH+1  number of pointers currently in the pool.
REQ-014 SHALL have port err_double_free_o  output  1  one-cycle pulse on a rejected free.
REQ-015 SHALL have port err_range_o  output  1  one-cycle pulse on a free with free_ptr_i >= DEPTH.

Function
REQ-016 SHALL hold pointers in a circular FIFO of DEPTH entries (read pointer, write pointer, count), storage without reset.
REQ-017 SHALL run the FSM states INIT -> RUN; INIT writes entries 0..DEPTH-1 with values 0..DEPTH-1, one per cycle, then moves to RUN with free_cnt_o = DEPTH.
REQ-018 SHALL keep init_done_o = 0, alloc_val_o = 0 and free_ready_o = 0 throughout INIT.
REQ-019 SHALL present the FIFO head on alloc_ptr_o from a registered prefetch stage, so alloc_val_o asserts 1 cycle after the pool becomes non-empty.
REQ-020 SHALL complete an allocation on a cycle with alloc_val_o = 1 and alloc_ready_i = 1; alloc_ptr_o SHALL stay stable while alloc_val_o = 1 and alloc_ready_i = 0.
REQ-021 SHALL sustain one allocation per cycle while the pool holds at least 2 pointers.
REQ-022 SHALL drive free_ready_o = 1 combinationally in RUN whenever free_val_i = 1 and the free is legal.
REQ-023 SHALL treat a free as illegal if free_ptr_i >= DEPTH (err_range_o) or, when CHECK_DOUBLE_FREE = 1, if the bitmap bit for free_ptr_i is clear (err_double_free_o); illegal frees are dropped without changing any state.
REQ-024 SHALL set the bitmap bit on allocation and clear it on a legal free; the bitmap SHALL be all-zero after INIT.
REQ-025 SHALL, on simultaneous allocation and legal free, perform both, leaving free_cnt_o unchanged; a freed pointer equal to the one allocated in the same cycle is a double free and is rejected.
REQ-026 SHALL, when the pool is empty, hold alloc_val_o = 0; a free into an empty pool is offered on alloc_ptr_o after 2 cycles (write, then prefetch).
REQ-027 SHALL never exceed DEPTH in free_cnt_o; with CHECK_DOUBLE_FREE = 0, a free at count = DEPTH SHALL be dropped and pulse err_double_free_o.
REQ-028 SHALL wrap the FIFO read and write pointers from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-029 SHALL count free_cnt_o including the pointer held in the prefetch register.

Reset
REQ-030 SHALL, on rst_i = 0 asynchronously, force the FSM to INIT, init_done_o = 0, alloc_val_o = 0, alloc_ptr_o = 0, free_ready_o = 0, free_cnt_o = 0, err pulses = 0, and the INIT counter, FIFO pointers and bitmap to 0.
REQ-031 SHALL, on reset asserted mid-operation, discard all outstanding allocations and restart INIT after release; previously issued pointers become free again.
REQ-032 SHALL deassert reset synchronously to clk_i internally (two-stage synchroniser) before leaving INIT.

Verification
REQ-033 SHALL cover: DEPTH = 8, release reset -> init_done_o after 8 cycles of INIT, free_cnt_o = 8, alloc_val_o = 1 with alloc_ptr_o = 0.
REQ-034 SHALL cover: alloc_ready_i held at 1 for 8 cycles -> pointers 0..7 issued in order, alloc_val_o = 0, free_cnt_o = 0.
REQ-035 SHALL cover: free pointer 5 into an empty pool -> free_ready_o = 1, and 2 cycles later alloc_val_o = 1 with alloc_ptr_o = 5.
REQ-036 SHALL cover: free pointer 3 twice -> second free gets free_ready_o = 0 and err_double_free_o pulses; free pointer 9 with DEPTH = 8 -> err_range_o pulses.
REQ-037 SHALL cover: simultaneous allocation and free at free_cnt_o = 4 -> free_cnt_o stays 4; FIFO wraps correctly over 3 full cycles with DEPTH = 6.
REQ-038 SHALL cover: reset asserted after 3 allocations -> all outputs at reset values immediately; after INIT, free_cnt_o = DEPTH and alloc_ptr_o = 0.
